// File: rtl/spike_event_arbiter.sv
// Spike event arbiter: one pending slot per neuron, round-robin serialisation onto
// a valid/ready synapse-update bus, plus the layer time-window counter.
module spike_event_arbiter #(
  parameter int N_SRC   = 4,
  parameter int DELAY_W = 4,
  parameter int WIN_LEN = 16,
  parameter int TS_W    = 4,
  localparam int SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [N_SRC-1:0]         spike_in,
  input  logic [N_SRC*DELAY_W-1:0] delay_in,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [SRC_W-1:0]         ev_src,
  output logic [DELAY_W-1:0]       ev_delay,
  output logic [TS_W-1:0]          ev_ts,
  output logic                     t_win,
  output logic                     win_start,
  output logic [N_SRC-1:0]         drop_flags,
  input  logic                     clr_drop,
  output logic                     idle
);

  localparam logic [TS_W-1:0]  WIN_LAST = TS_W'(WIN_LEN - 1);
  localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(N_SRC - 1);

  logic [TS_W-1:0]    win_cnt;
  logic [N_SRC-1:0]   pending;
  logic [DELAY_W-1:0] slot_delay [N_SRC];
  logic [TS_W-1:0]    slot_ts    [N_SRC];
  logic [SRC_W-1:0]   rr;

  logic [SRC_W-1:0]   winner;
  logic [SRC_W-1:0]   idx;
  logic               found;
  logic               load;
  logic [N_SRC-1:0]   take;
  logic [N_SRC-1:0]   cap;
  logic [N_SRC-1:0]   drop;
  logic [N_SRC-1:0]   pending_nxt;

  // Cyclic first-set search starting at the round-robin pointer.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = SRC_W'((int'(rr) + k) % N_SRC);
      if (!found && pending[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    load        = (!ev_valid || ev_ready) && (|pending);
    take        = load ? (N_SRC'(1) << winner) : '0;
    cap         = en ? spike_in : '0;
    // A slot leaving for the output this edge can be refilled without a drop.
    drop        = cap & pending & ~take;
    pending_nxt = (pending & ~take) | cap;
  end

  assign idle = ~(|pending) & ~ev_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt    <= '0;
      t_win      <= 1'b0;
      win_start  <= 1'b0;
      pending    <= '0;
      rr         <= '0;
      ev_valid   <= 1'b0;
      ev_src     <= '0;
      ev_delay   <= '0;
      ev_ts      <= '0;
      drop_flags <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        slot_delay[i] <= '0;
        slot_ts[i]    <= '0;
      end
    end else begin
      if (en) begin
        if (win_cnt == WIN_LAST) begin
          win_cnt   <= '0;
          t_win     <= ~t_win;
          win_start <= 1'b1;
        end else begin
          win_cnt   <= win_cnt + 1'b1;
          win_start <= 1'b0;
        end
      end else begin
        win_start <= 1'b0;
      end

      if (load) begin
        ev_valid <= 1'b1;
        ev_src   <= winner;
        ev_delay <= slot_delay[winner];
        ev_ts    <= slot_ts[winner];
        rr       <= (winner == SRC_LAST) ? '0 : winner + 1'b1;
      end else if (ev_ready) begin
        ev_valid <= 1'b0;
      end

      for (int i = 0; i < N_SRC; i++) begin
        if (cap[i] && (!pending[i] || take[i])) begin
          slot_delay[i] <= delay_in[i*DELAY_W +: DELAY_W];
          slot_ts[i]    <= win_cnt;
        end
      end
      pending <= pending_nxt;

      drop_flags <= clr_drop ? '0 : (drop_flags | drop);
    end
  end

endmodule
